// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-time debounce FSM,
// and registered press / release / long-press events plus a wrapping press count.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter bit          KEY_ACTIVE_LOW  = 1'b1,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             key_in,
   output logic             key_level,
   output logic             key_press,
   output logic             key_release,
   output logic             key_long,
   output logic             key_hold,
   output logic [CNT_W-1:0] press_cnt
);

   localparam int unsigned MAX_CYC = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
   localparam logic          REL_PIN   = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   logic              key_meta_p0;
   logic              key_raw_p1;
   logic              key_sync;

   state_t            state, state_nxt;
   logic [CW-1:0]     db_cnt, db_nxt;
   logic [CW-1:0]     hold_cnt, hold_nxt;
   logic              level_nxt, press_nxt, release_nxt, long_nxt, khold_nxt;
   logic [CNT_W-1:0]  pcnt_nxt;
   logic              long_hit;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= LONG_MAX) ? LONG_MAX : v + 1'b1;
   endfunction

   // Stage p0/p1: metastability filter, flops idle at the released pin level
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         key_meta_p0 <= REL_PIN;
         key_raw_p1  <= REL_PIN;
      end else begin
         key_meta_p0 <= key_in;
         key_raw_p1  <= key_meta_p0;
      end
   end

   assign key_sync = key_raw_p1 ^ KEY_ACTIVE_LOW;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state       <= RELEASED;
         db_cnt      <= '0;
         hold_cnt    <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_hold    <= 1'b0;
         press_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         db_cnt      <= db_nxt;
         hold_cnt    <= hold_nxt;
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_long    <= long_nxt;
         key_hold    <= khold_nxt;
         press_cnt   <= pcnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      db_nxt      = db_cnt;
      hold_nxt    = hold_cnt;
      level_nxt   = key_level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      khold_nxt   = key_hold;
      pcnt_nxt    = press_cnt;
      long_hit    = 1'b0;

      // Hold time keeps running through a release bounce; saturation makes the long event one-shot
      if (state == PRESSED || state == RELEASE_WAIT) begin
         hold_nxt = sat_inc(hold_cnt);
         long_hit = (hold_cnt == LONG_LAST);
      end
      if (long_hit) begin
         long_nxt  = 1'b1;
         khold_nxt = 1'b1;
      end

      case (state)
         RELEASED: begin
            if (key_sync) begin
               state_nxt = PRESS_WAIT;
               db_nxt    = CW'(1);
            end else begin
               db_nxt    = '0;
            end
         end
         PRESS_WAIT: begin
            if (!key_sync) begin
               state_nxt = RELEASED;
               db_nxt    = '0;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = PRESSED;
               db_nxt    = '0;
               hold_nxt  = '0;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
               pcnt_nxt  = press_cnt + 1'b1;
            end else begin
               db_nxt    = db_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!key_sync) begin
               state_nxt = RELEASE_WAIT;
               db_nxt    = CW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (key_sync) begin
               state_nxt = PRESSED;
               db_nxt    = '0;
            end else if (db_cnt == DB_LAST) begin
               // A coinciding long event wins; the release is taken on the following cycle
               if (!long_hit) begin
                  state_nxt   = RELEASED;
                  db_nxt      = '0;
                  hold_nxt    = '0;
                  level_nxt   = 1'b0;
                  release_nxt = 1'b1;
                  khold_nxt   = 1'b0;
               end
            end else begin
               db_nxt = db_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = RELEASED;
            db_nxt    = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboarded bench for key_debounce: run-length reference model feeds an
// expectation queue that a negedge monitor drains against the DUT outputs.
module tb_key_debounce;

   localparam int D     = 8;
   localparam int L     = 40;
   localparam int CNT_W = 8;

   logic             sys_clk = 1'b0;
   logic             rst;
   logic             key_in;
   logic             key_level, key_press, key_release, key_long, key_hold;
   logic [CNT_W-1:0] press_cnt;

   key_debounce #(
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .KEY_ACTIVE_LOW  (1'b1),
      .CNT_W           (CNT_W)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .key_hold    (key_hold),
      .press_cnt   (press_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pack(input logic lv, input logic pr, input logic rl,
                                        input logic lg, input logic hd, input logic [CNT_W-1:0] c);
      return {19'b0, lv, pr, rl, lg, hd, c};
   endfunction

   // Reference model: a level change is accepted once the synchronized key has
   // held the opposite value for D sampled edges; long fires L edges after a press.
   logic [31:0]      exp_q[$];
   logic             m_p1 = 1'b1, m_p2 = 1'b1;
   int               m_run = 0;
   logic             m_run_val = 1'b0;
   logic             m_level = 1'b0, m_hold = 1'b0;
   int               m_since = 0;
   logic [CNT_W-1:0] m_cnt = '0;
   logic             ms, mpress, mrel, mlong;

   always @(posedge sys_clk) begin
      mpress = 1'b0;
      mrel   = 1'b0;
      mlong  = 1'b0;
      if (rst) begin
         m_p1 = 1'b1; m_p2 = 1'b1;
         m_run = 0; m_run_val = 1'b0;
         m_level = 1'b0; m_hold = 1'b0; m_since = 0; m_cnt = '0;
      end else begin
         ms   = ~m_p2;
         m_p2 = m_p1;
         m_p1 = key_in;
         if (ms == m_run_val) m_run++;
         else begin
            m_run_val = ms;
            m_run     = 1;
         end
         if (m_level) m_since++;
         if (m_level && m_since == L) begin
            mlong  = 1'b1;
            m_hold = 1'b1;
         end
         if (!m_level && ms && m_run >= D) begin
            mpress  = 1'b1;
            m_level = 1'b1;
            m_cnt   = m_cnt + 1'b1;
            m_since = 0;
         end else if (m_level && !ms && m_run >= D && !mlong) begin
            mrel    = 1'b1;
            m_level = 1'b0;
            m_hold  = 1'b0;
         end
      end
      exp_q.push_back(pack(m_level, mpress, mrel, mlong, m_hold, m_cnt));
   end

   // Monitor: compare every presented cycle, and log pulse events for latency checks
   int          n_press = 0, n_rel = 0, n_long = 0;
   int          last_press_cyc = 0, last_rel_cyc = 0, last_long_cyc = 0;
   logic [31:0] mon_exp;

   always @(negedge sys_clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         chk("outputs", pack(key_level, key_press, key_release, key_long, key_hold, press_cnt), mon_exp);
      end
      if (key_long === 1'b1 || key_release === 1'b1)
         chk("long_release_exclusive", 32'(key_long & key_release), 32'd0);
      if (key_press === 1'b1)   begin n_press++; last_press_cyc = cyc; end
      if (key_release === 1'b1) begin n_rel++;   last_rel_cyc   = cyc; end
      if (key_long === 1'b1)    begin n_long++;  last_long_cyc  = cyc; end
   end

   task automatic set_in(input logic pin, input logic r);
      @(negedge sys_clk);
      key_in = pin;
      rst    = r;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   int t0, np0, nr0, nl0, len, r;

   initial begin
      rst    = 1'b1;
      key_in = 1'b1;
      wait_cyc(3);
      chk("reset_state", pack(key_level, key_press, key_release, key_long, key_hold, press_cnt), 32'd0);
      set_in(1'b1, 1'b0);
      wait_cyc(5);

      // Bounce: 5 low / 1 high for 60 cycles never reaches the stable count
      np0 = n_press;
      for (int i = 0; i < 60; i++) set_in((i % 6) == 5, 1'b0);
      set_in(1'b1, 1'b0);
      wait_cyc(12);
      chk("bounce_no_press", 32'(n_press - np0), 32'd0);
      chk("bounce_level", 32'(key_level), 32'd0);
      chk("bounce_cnt", 32'(press_cnt), 32'd0);

      // Clean press held 60 cycles: press latency, long latency, release latency
      np0 = n_press; nl0 = n_long; nr0 = n_rel;
      set_in(1'b0, 1'b0);
      t0 = cyc;
      wait_cyc(14);
      chk("press_latency", 32'(last_press_cyc - t0), 32'd10);
      chk("press_once", 32'(n_press - np0), 32'd1);
      chk("press_level", 32'(key_level), 32'd1);
      chk("press_cnt_1", 32'(press_cnt), 32'd1);
      wait_cyc(45);
      chk("long_latency", 32'(last_long_cyc - last_press_cyc), 32'd40);
      chk("long_once", 32'(n_long - nl0), 32'd1);
      chk("hold_before_release", 32'(key_hold), 32'd1);
      set_in(1'b1, 1'b0);
      t0 = cyc;
      wait_cyc(14);
      chk("release_latency", 32'(last_rel_cyc - t0), 32'd10);
      chk("release_once", 32'(n_rel - nr0), 32'd1);
      chk("hold_after_release", 32'(key_hold), 32'd0);
      chk("level_after_release", 32'(key_level), 32'd0);

      // Release glitch of 3 cycles while pressed
      set_in(1'b0, 1'b0);
      wait_cyc(20);
      np0 = n_press; nr0 = n_rel;
      set_in(1'b1, 1'b0);
      wait_cyc(2);
      set_in(1'b0, 1'b0);
      wait_cyc(20);
      chk("glitch_no_release", 32'(n_rel - nr0), 32'd0);
      chk("glitch_no_press", 32'(n_press - np0), 32'd0);
      chk("glitch_level", 32'(key_level), 32'd1);
      set_in(1'b1, 1'b0);
      wait_cyc(14);

      // Reset mid-press, key still held when reset drops
      set_in(1'b0, 1'b0);
      wait_cyc(15);
      set_in(1'b0, 1'b1);
      @(posedge sys_clk); #1;
      chk("midpress_reset", pack(key_level, key_press, key_release, key_long, key_hold, press_cnt), 32'd0);
      set_in(1'b0, 1'b1);
      set_in(1'b0, 1'b0);
      t0 = cyc;
      wait_cyc(14);
      chk("repress_latency", 32'(last_press_cyc - t0), 32'd10);
      chk("repress_cnt", 32'(press_cnt), 32'd1);
      set_in(1'b1, 1'b0);
      wait_cyc(14);

      // Counter wrap: clear the count, then 256 clean press/release cycles
      set_in(1'b1, 1'b1);
      set_in(1'b1, 1'b1);
      set_in(1'b1, 1'b0);
      wait_cyc(4);
      np0 = n_press; nr0 = n_rel;
      for (int i = 0; i < 256; i++) begin
         set_in(1'b0, 1'b0);
         wait_cyc(11);
         set_in(1'b1, 1'b0);
         wait_cyc(11);
      end
      wait_cyc(4);
      chk("wrap_cnt", 32'(press_cnt), 32'd0);
      chk("wrap_presses", 32'(n_press - np0), 32'd256);
      chk("wrap_releases", 32'(n_rel - nr0), 32'd256);

      // Randomized pin runs with occasional resets, checked by the scoreboard
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 39);
         if (r == 0) begin
            set_in(key_in, 1'b1);
            wait_cyc($urandom_range(0, 1));
            set_in(key_in, 1'b0);
         end
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 60) : $urandom_range(1, 12);
         set_in(~key_in, 1'b0);
         wait_cyc(len - 1);
      end
      set_in(1'b1, 1'b0);
      wait_cyc(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the LED output path: conditions one asynchronous push-button pin into clean, synchronous events for the user logic in the sys_clk domain (e.g. the LED flasher).
- Synchronizes the pin and debounces it by stable-time filtering.
- Emits single-cycle press, release and long-press pulses, a debounced level, and a wrapping press counter.
- Instantiated beside the LED logic, clocked from the clock-wizard output; its reset is driven from the inverted PLL-locked signal.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); legal range >= 2.
LONG_CYCLES, 50000000, cycles held pressed (counted from accepted press) before long-press pulse (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES.
KEY_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
CNT_W, 8, width of press counter.

Ports:
sys_clk  input  1  module clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
key_in  input  1  raw asynchronous button pin.
key_level  output  1  debounced level, 1 = pressed.
key_press  output  1  one-cycle pulse on accepted press.
key_release  output  1  one-cycle pulse on accepted release.
key_long  output  1  one-cycle pulse when held LONG_CYCLES.
key_hold  output  1  level, high from key_long until accepted release.
press_cnt  output  CNT_W  count of accepted presses, wraps.

Behaviour:
- Synchronizer: two flops on key_in, then polarity normalised to key_sync (1 = pressed). Flops reset to the released value.
- Edge numbering: edge 0 is the first sys_clk edge that samples the new pin value. key_sync shows that value after edge 1.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is RELEASED.
- RELEASED:
  - key_sync = 1 -> PRESS_WAIT, debounce counter = 1.
- PRESS_WAIT:
  - key_sync = 1: counter increments.
  - Counter reaching DEBOUNCE_CYCLES -> PRESSED; key_level = 1, key_press = 1 for one cycle, press_cnt += 1, hold counter = 0.
  - key_sync = 0 in any cycle -> RELEASED, counter cleared, no pulse (bounce rejected).
- PRESSED:
  - Hold counter increments each cycle, saturating.
  - Hold counter reaching LONG_CYCLES -> key_long = 1 for one cycle and key_hold = 1. Fires at most once per press; no auto-repeat.
  - key_sync = 0 -> RELEASE_WAIT, counter = 1. The hold counter keeps running.
- RELEASE_WAIT:
  - key_sync = 0: counter increments.
  - Counter reaching DEBOUNCE_CYCLES -> RELEASED; key_level = 0, key_release = 1 for one cycle, key_hold = 0.
  - key_sync = 1 -> PRESSED. No pulse, and the hold counter is not cleared.
- Latency: for a clean edge, the pulse is high in the cycle after edge DEBOUNCE_CYCLES+1.
- Output reset values: all outputs are 0, press_cnt = 0, all counters = 0.
- Outputs are registered; there is no combinational path from key_in.
- press_cnt wraps from 2^CNT_W-1 to 0 without any flag.
- key_long and key_release never assert in the same cycle. If the long threshold is reached while in RELEASE_WAIT, key_long still fires, and key_release follows later.
- Reset mid-operation:
  - rst high -> next edge returns to RELEASED with all outputs and counters cleared, even mid-press.
  - If the button is still held when rst deasserts, a fresh press is accepted after DEBOUNCE_CYCLES, and key_press fires.
- Counter widths are sized by clog2 of the larger threshold; no overflow is possible.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=8, LONG_CYCLES=40, KEY_ACTIVE_LOW=1.
- Clean press: key_in 1->0 held -> key_press high in exactly one cycle, 10 edges after the change; key_level=1; press_cnt=1.
- Bounce rejection: key_in toggles low 5 cycles / high 1 cycle repeatedly for 60 cycles -> no key_press, key_level stays 0, press_cnt=0.
- Long press: hold key_in=0 for 60 cycles then release -> key_press once; key_long once, 40 cycles after key_press; key_hold high until key_release; key_release 10 edges after the pin goes high.
- Release glitch: while pressed, key_in=1 for 3 cycles then back to 0 -> no key_release, key_level stays 1, no second key_press.
- Counter wrap: 256 clean press/release cycles with CNT_W=8 -> press_cnt returns to 0, with exactly 256 key_press and 256 key_release pulses.
- Reset mid-press: assert rst for 2 cycles while key_in=0 and key_level=1 -> all outputs 0 the edge after rst; after rst drops with key still held, key_press fires again after 10 edges and press_cnt=1.
